// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply/divide unit for the EX stage.
//
// Executes MULTU/MULT/DIVU/DIV on WIDTH-bit operands, one step per cycle.
// Signed operations run the unsigned core on operand magnitudes and fix the
// signs of the result on the final step.
//
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - asynchronous reset, active low
//   req_i    - operation request, taken only in IDLE or DONE
//   op_i     - 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a_i      - multiplicand / dividend
//   b_i      - multiplier / divisor
//   flush_i  - abort; returns to IDLE on the next edge, results untouched
//   busy_o   - operation in flight (RUN)
//   done_o   - one-cycle completion pulse; hi_o/lo_o valid from this cycle
//   div0_o   - last completed operation was a divide by zero
//   hi_o     - product upper half / remainder
//   lo_o     - product lower half / quotient
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div0_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Architectural state
    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic              neg_res_q, neg_res_d;  // negate product / quotient
    logic              neg_rem_q, neg_rem_d;  // negate remainder
    // {acc_hi, acc_lo} is the 2*WIDTH accumulator. Multiply: product upper
    // half and shifting multiplier. Divide: partial remainder and the
    // dividend shifting out as quotient bits shift in.
    logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]  acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;        // multiplicand / divisor magnitude
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              div0_q, div0_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Operand preparation
    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  a_mag, b_mag;

    // One iteration step
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_shift;
    logic [WIDTH:0]    div_diff;
    logic [WIDTH-1:0]  step_hi, step_lo;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic [WIDTH-1:0]  quo, rem;

    always_comb begin : operand_prep
        a_neg = op_i[0] & a_i[WIDTH-1];
        b_neg = op_i[0] & b_i[WIDTH-1];
        a_mag = a_neg ? -a_i : a_i;
        b_mag = b_neg ? -b_i : b_i;
    end

    always_comb begin : step_logic
        // Shift-add: add the multiplicand when the multiplier LSB is set, then
        // shift the whole accumulator right by one.
        mul_sum   = {1'b0, acc_hi_q} + ({1'b0, opnd_q} & {(WIDTH + 1){acc_lo_q[0]}});
        // Restoring division: bring in the next dividend bit and trial-subtract.
        // The partial remainder is below the divisor, so div_shift is below
        // twice the divisor and div_diff[WIDTH] is exactly the borrow.
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};

        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end

        // Sign fix-up applied to the final step's result. MIN / -1 comes out
        // of the magnitude core as 2^(WIDTH-1), which already equals MIN.
        prod_mag = {step_hi, step_lo};
        prod     = neg_res_q ? -prod_mag : prod_mag;
        quo      = neg_res_q ? -step_lo : step_lo;
        rem      = neg_rem_q ? -step_hi : step_hi;
    end

    always_comb begin : next_state
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        div0_d    = div0_q;

        if (flush_i) begin
            // Flush beats everything, including a same-cycle request.
            state_d = StIdle;
        end else begin
            case (state_q)
                StRun: begin
                    acc_hi_d = step_hi;
                    acc_lo_d = step_lo;
                    cnt_d    = cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        state_d = StDone;
                        div0_d  = 1'b0;
                        if (is_div_q) begin
                            hi_d = rem;
                            lo_d = quo;
                        end else begin
                            hi_d = prod[2*WIDTH-1:WIDTH];
                            lo_d = prod[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    // IDLE and DONE are both ready; DONE lasts one cycle.
                    state_d = StIdle;
                    if (req_i) begin
                        is_div_d  = op_i[1];
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        cnt_d     = '0;
                        acc_hi_d  = '0;
                        if (op_i[1] && (b_i == '0)) begin
                            // Divide by zero completes immediately.
                            state_d = StDone;
                            hi_d    = a_i;
                            lo_d    = '1;
                            div0_d  = 1'b1;
                        end else if (op_i[1]) begin
                            state_d  = StRun;
                            acc_lo_d = a_mag;
                            opnd_d   = b_mag;
                        end else begin
                            state_d  = StRun;
                            acc_lo_d = b_mag;
                            opnd_d   = a_mag;
                        end
                    end
                end
            endcase
        end

        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            div0_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            div0_q    <= div0_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign div0_o = div0_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: bench for mul_div_unit at WIDTH=32 (index 0) and WIDTH=8
// (index 1). A cycle-level reference built on plain 64-bit arithmetic is
// compared against both instances on every falling edge; directed scenarios
// add literal expectations, then randomized operations follow.
module tb_mul_div_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        req   [2];
    logic [1:0]  op    [2];
    logic [31:0] a     [2];
    logic [31:0] b     [2];
    logic        flush [2];

    logic        busy32, done32, div032;
    logic [31:0] hi32, lo32;
    logic        busy8, done8, div08;
    logic [7:0]  hi8, lo8;

    mul_div_unit #(.WIDTH(32)) dut32 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req[0]), .op_i(op[0]), .a_i(a[0]), .b_i(b[0]),
        .flush_i(flush[0]), .busy_o(busy32), .done_o(done32), .div0_o(div032),
        .hi_o(hi32), .lo_o(lo32)
    );

    mul_div_unit #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req[1]), .op_i(op[1]), .a_i(a[1][7:0]),
        .b_i(b[1][7:0]), .flush_i(flush[1]), .busy_o(busy8), .done_o(done8), .div0_o(div08),
        .hi_o(hi8), .lo_o(lo8)
    );

    logic        o_busy [2];
    logic        o_done [2];
    logic        o_div0 [2];
    logic [31:0] o_hi   [2];
    logic [31:0] o_lo   [2];
    assign o_busy[0] = busy32;
    assign o_busy[1] = busy8;
    assign o_done[0] = done32;
    assign o_done[1] = done8;
    assign o_div0[0] = div032;
    assign o_div0[1] = div08;
    assign o_hi[0]   = hi32;
    assign o_hi[1]   = {24'd0, hi8};
    assign o_lo[0]   = lo32;
    assign o_lo[1]   = {24'd0, lo8};

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int wid(input int i);
        return (i == 0) ? 32 : 8;
    endfunction

    // Architectural result of one operation at width w.
    function automatic void ref_op(input int w, input logic [1:0] o, input logic [31:0] ai,
                                   input logic [31:0] bi, output logic [31:0] hi,
                                   output logic [31:0] lo, output logic d0);
        logic [63:0] mask, ua, ub, t;
        longint      sa, sb;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, ai} & mask;
        ub   = {32'd0, bi} & mask;
        sa   = (o[0] && ua[w-1]) ? longint'(ua | ~mask) : longint'(ua);
        sb   = (o[0] && ub[w-1]) ? longint'(ub | ~mask) : longint'(ub);
        d0   = 1'b0;
        if (!o[1]) begin
            t  = sa * sb;
            hi = 32'((t >> w) & mask);
            lo = 32'(t & mask);
        end else if (ub == 64'd0) begin
            hi = 32'(ua);
            lo = 32'(mask);
            d0 = 1'b1;
        end else begin
            t  = sa / sb;
            lo = 32'(t & mask);
            t  = sa % sb;
            hi = 32'(t & mask);
        end
    endfunction

    // Timing reference: m_rem counts remaining busy cycles.
    int          m_rem  [2] = '{0, 0};
    logic        m_done [2] = '{1'b0, 1'b0};
    logic        m_d0   [2] = '{1'b0, 1'b0};
    logic [31:0] m_hi   [2] = '{32'd0, 32'd0};
    logic [31:0] m_lo   [2] = '{32'd0, 32'd0};
    logic [31:0] p_hi   [2] = '{32'd0, 32'd0};
    logic [31:0] p_lo   [2] = '{32'd0, 32'd0};
    logic        p_d0   [2] = '{1'b0, 1'b0};

    always @(posedge clk or negedge rst_n) begin : model
        logic [31:0] th, tl;
        logic        td;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_rem[i]  <= 0;
                m_done[i] <= 1'b0;
                m_d0[i]   <= 1'b0;
                m_hi[i]   <= '0;
                m_lo[i]   <= '0;
            end else if (flush[i]) begin
                m_rem[i]  <= 0;
                m_done[i] <= 1'b0;
            end else if (m_rem[i] > 0) begin
                m_rem[i]  <= m_rem[i] - 1;
                m_done[i] <= (m_rem[i] == 1);
                if (m_rem[i] == 1) begin
                    m_hi[i] <= p_hi[i];
                    m_lo[i] <= p_lo[i];
                    m_d0[i] <= p_d0[i];
                end
            end else begin
                m_done[i] <= 1'b0;
                if (req[i]) begin
                    ref_op(wid(i), op[i], a[i], b[i], th, tl, td);
                    if (td) begin
                        m_done[i] <= 1'b1;
                        m_hi[i]   <= th;
                        m_lo[i]   <= tl;
                        m_d0[i]   <= 1'b1;
                    end else begin
                        m_rem[i] <= wid(i);
                        p_hi[i]  <= th;
                        p_lo[i]  <= tl;
                        p_d0[i]  <= 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("busy[%0d]", i), 64'(o_busy[i]), 64'(m_rem[i] > 0));
                check($sformatf("done[%0d]", i), 64'(o_done[i]), 64'(m_done[i]));
                check($sformatf("div0[%0d]", i), 64'(o_div0[i]), 64'(m_d0[i]));
                check($sformatf("hi[%0d]", i), 64'(o_hi[i]), 64'(m_hi[i]));
                check($sformatf("lo[%0d]", i), 64'(o_lo[i]), 64'(m_lo[i]));
            end
        end
    end

    // Issue one request from just after a falling edge and follow it. Optional
    // mid-run pulse of req (and flush) at cycle pk. lat = -1 if no done seen.
    task automatic run_op(input int i, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int pk, input bit pflush,
                          input int budget, output int lat, output int bcnt);
        lat      = -1;
        bcnt     = 0;
        op[i]    = o;
        a[i]     = x;
        b[i]     = y;
        req[i]   = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (k == 1) req[i] = 1'b0;
            if (k == pk) begin
                req[i]   = 1'b1;
                op[i]    = 2'b00;
                a[i]     = 32'd3;
                b[i]     = 32'd3;
                flush[i] = pflush;
            end else if (k == pk + 1) begin
                req[i]   = 1'b0;
                flush[i] = 1'b0;
            end
            if (o_busy[i]) bcnt++;
            if (o_done[i]) begin
                lat = k;
                break;
            end
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'hFFFF_FF80;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int lat, bc, w, pk, exp_lat;
        bit pf, d0case;
        logic [1:0] o;
        logic [31:0] x, y;

        for (int i = 0; i < 2; i++) begin
            req[i]   = 1'b0;
            op[i]    = 2'b00;
            a[i]     = '0;
            b[i]     = '0;
            flush[i] = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        check("reset_busy", 64'(busy32), 64'd0);
        check("reset_done", 64'(done32), 64'd0);
        check("reset_hi", 64'(hi32), 64'd0);
        check("reset_lo8", 64'(lo8), 64'd0);
        chk_en = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // MULTU max * max
        run_op(0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 60, lat, bc);
        check("multu_lat", 64'(lat), 64'd33);
        check("multu_busy", 64'(bc), 64'd32);
        check("multu_hi", 64'(hi32), 64'hFFFF_FFFE);
        check("multu_lo", 64'(lo32), 64'h1);

        // MULT -3 * 7, then DIV -7 / 2 issued in the DONE cycle
        run_op(0, 2'b01, 32'hFFFF_FFFD, 32'd7, 0, 1'b0, 60, lat, bc);
        check("mult_hi", 64'(hi32), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo32), 64'hFFFF_FFEB);
        run_op(0, 2'b11, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 60, lat, bc);
        check("b2b_lat", 64'(lat), 64'd33);
        check("b2b_busy", 64'(bc), 64'd32);
        check("div_lo", 64'(lo32), 64'hFFFF_FFFD);
        check("div_hi", 64'(hi32), 64'hFFFF_FFFF);

        // DIVU by zero, then MULTU 2 * 3 from the DONE cycle
        @(negedge clk);
        run_op(0, 2'b10, 32'd100, 32'd0, 0, 1'b0, 60, lat, bc);
        check("div0_lat", 64'(lat), 64'd1);
        check("div0_busy", 64'(bc), 64'd0);
        check("div0_flag", 64'(div032), 64'd1);
        check("div0_lo", 64'(lo32), 64'hFFFF_FFFF);
        check("div0_hi", 64'(hi32), 64'd100);
        run_op(0, 2'b00, 32'd2, 32'd3, 0, 1'b0, 60, lat, bc);
        check("after_div0_flag", 64'(div032), 64'd0);
        check("after_div0_lo", 64'(lo32), 64'd6);

        // Flush with a simultaneous request in RUN cycle 10
        run_op(0, 2'b10, 32'd1000, 32'd7, 10, 1'b1, 45, lat, bc);
        check("flush_no_done", 64'(lat), 64'(-1));
        check("flush_busy", 64'(bc), 64'd10);
        check("flush_hi", 64'(hi32), 64'd0);
        check("flush_lo", 64'(lo32), 64'd6);
        // Request pulsed mid-RUN is ignored
        run_op(0, 2'b10, 32'd1000, 32'd7, 5, 1'b0, 60, lat, bc);
        check("midreq_lat", 64'(lat), 64'd33);
        check("midreq_lo", 64'(lo32), 64'd142);
        check("midreq_hi", 64'(hi32), 64'd6);
        @(negedge clk);
        check("midreq_idle", 64'(busy32), 64'd0);

        // WIDTH=8 overflow: -128 / -1
        run_op(1, 2'b11, 32'h80, 32'hFF, 0, 1'b0, 30, lat, bc);
        check("w8_lat", 64'(lat), 64'd9);
        check("w8_lo", 64'(lo8), 64'h80);
        check("w8_hi", 64'(hi8), 64'h00);
        check("w8_div0", 64'(div08), 64'd0);

        // Asynchronous reset mid-RUN
        op[0]  = 2'b00;
        a[0]   = 32'd123;
        b[0]   = 32'd456;
        req[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy32), 64'd0);
        check("arst_lo", 64'(lo32), 64'd0);
        check("arst_hi8", 64'(hi8), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_op(0, 2'b00, 32'd5, 32'd5, 0, 1'b0, 60, lat, bc);
        check("post_reset_lo", 64'(lo32), 64'd25);
        check("post_reset_hi", 64'(hi32), 64'd0);

        // Randomized operations on both instances
        for (int n = 0; n < 120; n++) begin
            int i;
            i  = $urandom_range(0, 1);
            w  = wid(i);
            o  = 2'($urandom_range(0, 3));
            x  = pick();
            y  = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
            pk = 0;
            pf = 1'b0;
            case ($urandom_range(0, 9))
                0, 1: begin pk = $urandom_range(2, w - 1); pf = 1'b1; end
                2:    pk = $urandom_range(2, w - 2);
                default: ;
            endcase
            d0case = o[1] && ((w == 8) ? (y[7:0] == 8'd0) : (y == 32'd0));
            if (d0case) pf = 1'b0;
            exp_lat = pf ? -1 : (d0case ? 1 : w + 1);
            run_op(i, o, x, y, pk, pf, w + 5, lat, bc);
            check($sformatf("rand_lat[%0d]", i), 64'(lat), 64'(exp_lat));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised iterative multiply/divide unit for the pipelined CPU's EX stage. It executes MULT, MULTU, DIV and DIVU over WIDTH-bit operands, one radix-2 step per cycle, and delivers a 2×WIDTH result split into HI and LO. It is the first multi-cycle execution resource in the datapath: the hazard logic holds the pipeline while `busy_o` is high, and a branch or exception squash aborts an in-flight operation through `flush_i`.

## Interface
- `WIDTH`, default 32: operand width and width of each result half; any value ≥ 4.
- `clk_i` input 1: clock; all state changes on the rising edge.
- `rst_i` input 1: asynchronous reset, active-low.
- `req_i` input 1: operation request; accepted only when the unit is ready.
- `op_i` input 2: operation select; 00 = MULTU, 01 = MULT, 10 = DIVU, 11 = DIV.
- `a_i` input WIDTH: multiplicand or dividend.
- `b_i` input WIDTH: multiplier or divisor.
- `flush_i` input 1: abort the current operation.
- `busy_o` output 1: an operation is in flight.
- `done_o` output 1: single-cycle pulse marking a completed operation; `hi_o`/`lo_o` are valid from this cycle.
- `div0_o` output 1: the last completed operation was a divide by zero; held until the next completion.
- `hi_o` output WIDTH: for multiplies, the product's upper half; for divides, the remainder.
- `lo_o` output WIDTH: for multiplies, the product's lower half; for divides, the quotient.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: iterating.
  - DONE: result presented.
- Ready condition: the state is IDLE or DONE. In that condition, `req_i` = 1 latches `op_i`, `a_i` and `b_i`.
- Signed ops (01, 11):
  - Operands are converted to magnitudes, and the unsigned core runs on the magnitudes.
  - Product is negated iff the operand signs differ.
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the dividend's sign.
- Multiply: shift-add over a 2×WIDTH accumulator, one multiplier bit per cycle.
- Divide: restoring division, one quotient bit per cycle, using a (WIDTH+1)-bit partial remainder.
- Iteration counter: $clog2(WIDTH)+1 bits. RUN lasts exactly WIDTH cycles, then the unit enters DONE.
- Divide by zero (`b_i` = 0 with op 1x):
  - Detected at acceptance; the unit goes straight to DONE and skips RUN.
  - Results: `lo_o` = all ones, `hi_o` = `a_i` (unmodified), `div0_o` = 1.
- Overflow: DIV of the most-negative value by −1 wraps. Quotient = most-negative value, remainder = 0, and `div0_o` = 0.
- Requests in RUN: `req_i` while in RUN is ignored; no queueing.
- Flush:
  - `flush_i` = 1 in any state forces IDLE on the next edge.
  - `hi_o`, `lo_o` and `div0_o` keep their old values.
  - No `done_o` pulse follows a flush.
- Simultaneous events:
  - `flush_i` and `req_i` in the same cycle: flush wins and the request is dropped.
  - `req_i` in DONE: the new request is accepted, and the unit goes to RUN (or back to DONE for a divide by zero).
- Reset (asynchronous, at any time including mid-operation):
  - State = IDLE.
  - `busy_o`, `done_o`, `div0_o` = 0.
  - `hi_o`, `lo_o` = 0.
  - Counter and accumulators cleared.

## Timing
- Acceptance edge E0: the edge at which `req_i` is sampled high while the unit is ready.
- `busy_o` is 1 from E0 through the last RUN cycle, and 0 in IDLE and DONE.
- Normal operation: `done_o` is high for exactly one cycle, after edge E0+WIDTH. Latency is WIDTH+1 cycles, counted from the request cycle to the done cycle.
- Divide by zero: `done_o` is high in the cycle after E0 (latency 1), and `busy_o` never rises.
- `hi_o`, `lo_o` and `div0_o` are registered outputs. They update only on the edge that enters DONE and are stable otherwise.
- Back-to-back: a request in the DONE cycle gives a continuous `busy_o` restart with no idle gap.
- No combinational path from any input to any output.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF (WIDTH = 32) → `hi_o` = 0xFFFFFFFE, `lo_o` = 0x00000001; `done_o` in cycle 33; `busy_o` high for 32 cycles.
- MULT −3 × 7 → `hi_o` = 0xFFFFFFFF, `lo_o` = 0xFFFFFFEB. Then a back-to-back DIV −7 / 2 issued in the DONE cycle → `lo_o` = 0xFFFFFFFD, `hi_o` = 0xFFFFFFFF.
- DIVU 100 / 0 → `done_o` in the cycle after acceptance, `div0_o` = 1, `lo_o` = 0xFFFFFFFF, `hi_o` = 100. A following MULTU 2 × 3 clears `div0_o` and gives `lo_o` = 6.
- Start DIVU 1000 / 7 and assert `flush_i` in RUN cycle 10 together with `req_i` → `busy_o` low next cycle, no `done_o`, `hi_o`/`lo_o` unchanged, request dropped. A `req_i` pulsed mid-RUN in a separate run is ignored.
- WIDTH = 8, DIV 0x80 / 0xFF → `lo_o` = 0x80, `hi_o` = 0x00, `div0_o` = 0; `done_o` in cycle 9.
- Drive `rst_i` low asynchronously (between edges) mid-RUN → all outputs 0 immediately. After release, a new MULTU 5 × 5 completes with `lo_o` = 25.
